// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, issues single-outstanding word fetches,
// buffers responses in a small FIFO and drives the IF/ID register. FETCH_PERF_EN adds perf counters.
module inst_fetch #(
    parameter int                 ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC  = 32'h0000_0000,
    parameter int                 BUF_DEPTH = 2,
    parameter logic [31:0]        NOP_INST  = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              resetIn,
    output logic              memReq,
    output logic [ADDR_W-1:0] memAddr,
    input  logic              memReady,
    input  logic              memRdValid,
    input  logic [31:0]       memRdData,
    input  logic              stallIn,
    input  logic              redirectValid,
    input  logic [ADDR_W-1:0] redirectPC,
    output logic [31:0]       instOut,
    output logic [ADDR_W-1:0] pcOut,
    output logic              instValid,
    output logic              resetOut
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perfFetchCnt,
    output logic [31:0]       perfBubbleCnt
`endif
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(3'd4);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [ADDR_W-1:0] pc_r, pc_s, req_addr_r;
    logic [ADDR_W-1:0] redirect_addr_s;
    logic [ADDR_W-1:0] fifo_addr_r [BUF_DEPTH];
    logic [31:0]       fifo_data_r [BUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              req_s, handshake_s, push_s, pop_s, fifo_empty_s;
    logic [31:0]       inst_r;
    logic [ADDR_W-1:0] pc_out_r;
    logic              valid_r, reset_out_r;

    // Low two bits of a redirect target are masked rather than trusted.
    assign redirect_addr_s = redirectPC & ~ADDR_W'(2'b11);
    assign fifo_empty_s    = (count_r == {CNT_W{1'b0}});
    assign req_s           = (state_r == ST_IDLE) && !redirectValid && !resetIn
                             && (count_r < CNT_W'(BUF_DEPTH));
    assign handshake_s     = req_s && memReady;
    assign push_s          = (state_r == ST_WAIT) && memRdValid && !redirectValid;
    assign pop_s           = !redirectValid && !stallIn && !fifo_empty_s;

    assign memReq    = req_s;
    assign memAddr   = pc_r;
    assign instOut   = inst_r;
    assign pcOut     = pc_out_r;
    assign instValid = valid_r;
    assign resetOut  = reset_out_r;

    // Next-state and next-PC for the fetch FSM.
    always_comb begin
        state_s = state_r;
        pc_s    = pc_r;
        if (redirectValid) begin
            pc_s = redirect_addr_s;
            // A response still owed by memory must be swallowed before fetching again.
            if ((state_r != ST_IDLE) && !memRdValid) begin
                state_s = ST_DROP;
            end else begin
                state_s = ST_IDLE;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (handshake_s) begin
                        pc_s    = pc_r + PC_STEP;
                        state_s = ST_WAIT;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_WAIT, ST_DROP: begin
                    if (memRdValid) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = state_r;
                    end
                end
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // FSM state, PC and the address of the outstanding request.
    always_ff @(posedge clk or posedge resetIn) begin
        if (resetIn) begin
            state_r    <= ST_IDLE;
            pc_r       <= RESET_PC;
            req_addr_r <= RESET_PC;
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            if (handshake_s) begin
                req_addr_r <= pc_r;
            end
        end
    end

    // FIFO pointers and occupancy; a redirect empties the buffer.
    always_ff @(posedge clk or posedge resetIn) begin
        if (resetIn) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (redirectValid) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
        end
    end

    // FIFO storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_addr_r[wr_ptr_r] <= req_addr_r;
            fifo_data_r[wr_ptr_r] <= memRdData;
        end
    end

    // IF/ID holding register: redirect bubble beats stall, stall beats pop.
    always_ff @(posedge clk or posedge resetIn) begin
        if (resetIn) begin
            inst_r      <= NOP_INST;
            pc_out_r    <= {ADDR_W{1'b0}};
            valid_r     <= 1'b0;
            reset_out_r <= 1'b1;
        end else begin
            reset_out_r <= 1'b0;
            if (redirectValid) begin
                inst_r  <= NOP_INST;
                valid_r <= 1'b0;
            end else if (stallIn) begin
                inst_r   <= inst_r;
                pc_out_r <= pc_out_r;
                valid_r  <= valid_r;
            end else if (!fifo_empty_s) begin
                inst_r   <= fifo_data_r[rd_ptr_r];
                pc_out_r <= fifo_addr_r[rd_ptr_r];
                valid_r  <= 1'b1;
            end else begin
                inst_r  <= NOP_INST;
                valid_r <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic bubble_s;
    assign bubble_s = !stallIn && (redirectValid || fifo_empty_s);

    // Free-running fetch and bubble counters, wrapping at 2^32.
    always_ff @(posedge clk or posedge resetIn) begin
        if (resetIn) begin
            perfFetchCnt  <= 32'd0;
            perfBubbleCnt <= 32'd0;
        end else begin
            if (push_s) begin
                perfFetchCnt <= perfFetchCnt + 32'd1;
            end
            if (bubble_s) begin
                perfBubbleCnt <= perfBubbleCnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized scoreboard bench for inst_fetch: a memory model feeds the DUT, expected
// instructions are queued at request acceptance and popped by an independent output monitor.
module tb_inst_fetch;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        resetIn, memReq, memReady, memRdValid, stallIn, redirectValid;
    logic        instValid, resetOut;
    logic [31:0] memAddr, memRdData, redirectPC, instOut, pcOut;

    always #5 clk = ~clk;

    inst_fetch dut (
        .clk(clk), .resetIn(resetIn), .memReq(memReq), .memAddr(memAddr),
        .memReady(memReady), .memRdValid(memRdValid), .memRdData(memRdData),
        .stallIn(stallIn), .redirectValid(redirectValid), .redirectPC(redirectPC),
        .instOut(instOut), .pcOut(pcOut), .instValid(instValid), .resetOut(resetOut)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] tag(input logic [31:0] a);
        return a ^ 32'h5A00_00A5;
    endfunction

    // Scoreboard: {pc, inst} of every fetch the program order says must emerge.
    logic [63:0] exp_q[$];

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;
    pend_t pend_q[$];

    int          cyc = 0, stale_cnt = 0, ready_pct = 100, lat_min = 1, lat_max = 1, mon_valid = 0;
    logic [31:0] model_pc = RST_PC;
    logic        prev_wait_req = 1'b0;
    logic [31:0] prev_req_addr = 32'h0;
    logic        delivered = 1'b0;

    // Memory model: in-order responses with random latency; stale responses after reset arrive idle.
    initial begin : mem_model
        memReady = 1'b0; memRdValid = 1'b0; memRdData = 32'h0;
        forever begin
            @(posedge clk); #2;
            cyc++;
            delivered = 1'b0; memRdValid = 1'b0; memRdData = 32'h0;
            if (resetIn) begin
                memReady = 1'b0;
            end else if (stale_cnt > 0 && pend_q.size() > 0) begin
                memReady = 1'b0; memRdValid = 1'b1; memRdData = 32'hDEAD_BEEF; delivered = 1'b1;
            end else begin
                memReady = (int'($urandom_range(99, 0)) < ready_pct);
                if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                    memRdValid = 1'b1; memRdData = tag(pend_q[0].addr); delivered = 1'b1;
                end
            end
            @(negedge clk); #2;
            if (delivered) begin
                void'(pend_q.pop_front());
                if (stale_cnt > 0) stale_cnt--;
            end
            if (resetIn) begin
                stale_cnt = pend_q.size(); model_pc = RST_PC; prev_wait_req = 1'b0;
            end else begin
                if (prev_wait_req && !redirectValid) begin
                    chk("req_held", 32'(memReq), 32'd1);
                    chk("addr_held", memAddr, prev_req_addr);
                end
                if (redirectValid) begin
                    chk("req_during_redirect", 32'(memReq), 32'd0);
                    model_pc = redirectPC & 32'hFFFF_FFFC;
                end else if (memReq && memReady) begin
                    chk("fetch_addr", memAddr, model_pc);
                    pend_q.push_back('{addr: memAddr, due: cyc + int'($urandom_range(lat_max, lat_min))});
                    exp_q.push_back({model_pc, tag(model_pc)});
                    model_pc = model_pc + 32'd4;
                end
                prev_wait_req = memReq && !memReady && !redirectValid;
                prev_req_addr = memAddr;
            end
        end
    end

    logic        last_rst = 1'b1, last_stall = 1'b0, last_redir = 1'b0;
    logic [31:0] prev_inst = NOP, prev_pc = 32'h0;
    logic        prev_valid = 1'b0;
    logic [63:0] mon_e;

    // Output monitor: judges each IF/ID load from the inputs seen in the previous cycle.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (resetIn) begin
                chk("rst_memReq", 32'(memReq), 32'd0);
                chk("rst_memAddr", memAddr, RST_PC);
                chk("rst_instOut", instOut, NOP);
                chk("rst_pcOut", pcOut, 32'h0);
                chk("rst_instValid", 32'(instValid), 32'd0);
                chk("rst_resetOut", 32'(resetOut), 32'd1);
                exp_q.delete();
                last_rst = 1'b1;
            end else begin
                chk("resetOut", 32'(resetOut), 32'(last_rst));
                if (!last_rst) begin
                    if (last_redir) begin
                        chk("redir_bubble_valid", 32'(instValid), 32'd0);
                        chk("redir_bubble_inst", instOut, NOP);
                        chk("redir_bubble_pc", pcOut, prev_pc);
                    end else if (last_stall) begin
                        chk("stall_hold_inst", instOut, prev_inst);
                        chk("stall_hold_pc", pcOut, prev_pc);
                        chk("stall_hold_valid", 32'(instValid), 32'(prev_valid));
                    end else if (instValid) begin
                        if (exp_q.size() == 0) begin
                            n_checks++; n_fail++;
                            $display("FAIL unexpected_inst: got pc %h, expected no valid instruction", pcOut);
                        end else begin
                            mon_e = exp_q.pop_front();
                            chk("pc_out", pcOut, mon_e[63:32]);
                            chk("inst_out", instOut, mon_e[31:0]);
                            mon_valid++;
                        end
                    end else begin
                        chk("empty_bubble_inst", instOut, NOP);
                        chk("empty_bubble_pc", pcOut, prev_pc);
                    end
                end
                if (redirectValid) exp_q.delete();
                last_rst = 1'b0; last_stall = stallIn; last_redir = redirectValid;
            end
            prev_inst = instOut; prev_pc = pcOut; prev_valid = instValid;
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_outstanding(input string name);
        int i;
        for (i = 0; i < 60 && !(pend_q.size() > 0 && stale_cnt == 0); i++) step();
        chk(name, 32'(pend_q.size() > 0), 32'd1);
    endtask

    // Stimulus: directed scenarios followed by a randomized soak.
    initial begin : stim
        resetIn = 1'b1; stallIn = 1'b0; redirectValid = 1'b0; redirectPC = 32'h0;
        repeat (3) @(posedge clk);
        #1 resetIn = 1'b0;

        repeat (20) step();

        ready_pct = 0;
        repeat (4) step();
        chk("not_ready_req", 32'(memReq), 32'd1);
        chk("not_ready_addr", memAddr, model_pc);
        step();
        ready_pct = 100;
        repeat (6) step();

        stallIn = 1'b1;
        repeat (7) step();
        chk("stall_fifo_full_req", 32'(memReq), 32'd0);
        step();
        stallIn = 1'b0;
        repeat (10) step();

        lat_min = 3; lat_max = 3;
        wait_outstanding("redir_outstanding");
        redirectValid = 1'b1; redirectPC = 32'h0000_0103;
        step();
        redirectValid = 1'b0;
        repeat (15) step();

        lat_min = 1; lat_max = 1;
        stallIn = 1'b1; redirectValid = 1'b1; redirectPC = 32'hFFFF_FFF9;
        step();
        redirectValid = 1'b0;
        step();
        stallIn = 1'b0;
        repeat (15) step();

        ready_pct = 70; lat_min = 1; lat_max = 3;
        for (int i = 0; i < 400; i++) begin
            stallIn       = (int'($urandom_range(99, 0)) < 20);
            redirectValid = (int'($urandom_range(99, 0)) < 5);
            redirectPC    = $urandom();
            step();
        end
        stallIn = 1'b0; redirectValid = 1'b0;
        repeat (10) step();

        ready_pct = 100; lat_min = 4; lat_max = 4;
        wait_outstanding("reset_outstanding");
        #2 resetIn = 1'b1;
        #1;
        chk("async_rst_memReq", 32'(memReq), 32'd0);
        chk("async_rst_memAddr", memAddr, RST_PC);
        chk("async_rst_instOut", instOut, NOP);
        chk("async_rst_pcOut", pcOut, 32'h0);
        chk("async_rst_instValid", 32'(instValid), 32'd0);
        chk("async_rst_resetOut", 32'(resetOut), 32'd1);
        step(); step();
        resetIn = 1'b0;
        lat_min = 1; lat_max = 1;
        mon_valid = 0;
        repeat (20) step();
        chk("restart_progress", 32'(mon_valid > 0), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

endmodule
